// File: rtl/dispense_sequencer.sv
// dispense_sequencer: takes the controller's candy strobe and the change it
// reports, then drives the candy solenoid, the large-coin ejector and the
// small-coin ejector one actuation at a time, with a fixed all-off gap between
// consecutive actuations. The candy drop is confirmed by drop_sense; a missing
// drop leads to a sticky error that err_ack clears.
//
// Optional build macro DISPENSE_STATS_EN adds saturating counters of confirmed
// vends (vend_total) and ejected coins (coin_total).
//
// Request protocol: the controller raises candy as a level; a job is taken on
// the single cycle where candy is high and was low on the previous cycle. The
// change inputs are sampled on that same cycle. No acknowledge is returned; a
// job that cannot be buffered is dropped and flagged with a one-cycle overflow.

module dispense_sequencer #(
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 1,
  parameter int TIMEOUT   = 8,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       candy,
  input  logic [2:0] change_beg,
  input  logic       change_obeg,
  input  logic       drop_sense,
  input  logic       err_ack,
  output logic       candy_sol,
  output logic       obeg_eject,
  output logic       beg_eject,
  output logic       busy,
  output logic       error,
  output logic       overflow
`ifdef DISPENSE_STATS_EN
  ,
  output logic [7:0] vend_total,
  output logic [7:0] coin_total
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CANDY_ON  = 3'd1,
    WAIT_DROP = 3'd2,
    GAP       = 3'd3,
    OBEG_ON   = 3'd4,
    BEG_ON    = 3'd5,
    ERROR     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

  // state is the FSM register; checkers can bind to it directly.
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             candy_q;
  logic             drop_seen;   // drop observed while the solenoid was still on
  logic [2:0]       act_beg;
  logic             act_obeg;
  logic             pend_valid;
  logic [2:0]       pend_beg;
  logic             pend_obeg;
  logic             new_job;

  assign new_job = candy & ~candy_q;

  // busy is decoded from registers only, so no input reaches it combinationally
  assign busy = (state != IDLE) | pend_valid;

  // Previous value of the request level for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) candy_q <= 1'b0;
    else        candy_q <= candy;
  end

  // Sequencer FSM with job buffer, actuator drives and error/overflow flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      drop_seen  <= 1'b0;
      act_beg    <= 3'd0;
      act_obeg   <= 1'b0;
      pend_valid <= 1'b0;
      pend_beg   <= 3'd0;
      pend_obeg  <= 1'b0;
      candy_sol  <= 1'b0;
      obeg_eject <= 1'b0;
      beg_eject  <= 1'b0;
      error      <= 1'b0;
      overflow   <= 1'b0;
`ifdef DISPENSE_STATS_EN
      vend_total <= 8'd0;
      coin_total <= 8'd0;
`endif
    end else begin
      overflow <= 1'b0;

      // A request arriving while a job runs goes to the single pending slot;
      // with the slot taken, or while in ERROR, it is dropped.
      if (new_job && state != IDLE) begin
        if (state == ERROR || pend_valid) begin
          overflow <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_beg   <= change_beg;
          pend_obeg  <= change_obeg;
        end
      end

      case (state)
        IDLE: begin
          if (pend_valid) begin
            // The slot is still full on this cycle, so a fresh request is lost
            act_beg    <= pend_beg;
            act_obeg   <= pend_obeg;
            pend_valid <= 1'b0;
            state      <= CANDY_ON;
            candy_sol  <= 1'b1;
            cnt        <= '0;
            drop_seen  <= 1'b0;
            if (new_job) overflow <= 1'b1;
          end else if (new_job) begin
            act_beg   <= change_beg;
            act_obeg  <= change_obeg;
            state     <= CANDY_ON;
            candy_sol <= 1'b1;
            cnt       <= '0;
            drop_seen <= 1'b0;
          end
        end

        CANDY_ON: begin
          if (drop_sense) drop_seen <= 1'b1;
          if (cnt == PULSE_LAST) begin
            candy_sol <= 1'b0;
            state     <= WAIT_DROP;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_DROP: begin
          if (drop_sense || drop_seen) begin
            drop_seen <= 1'b0;
            state     <= GAP;
            cnt       <= '0;
`ifdef DISPENSE_STATS_EN
            if (vend_total != 8'hFF) vend_total <= vend_total + 8'd1;
`endif
          end else if (cnt == TO_LAST) begin
            // Timeout: abandon the job's change and flush anything queued
            state      <= ERROR;
            error      <= 1'b1;
            pend_valid <= 1'b0;
            cnt        <= '0;
            if (new_job) overflow <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (act_obeg) begin
              state      <= OBEG_ON;
              obeg_eject <= 1'b1;
            end else if (act_beg != 3'd0) begin
              state     <= BEG_ON;
              beg_eject <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        OBEG_ON: begin
          if (cnt == PULSE_LAST) begin
            obeg_eject <= 1'b0;
            act_obeg   <= 1'b0;
            state      <= GAP;
            cnt        <= '0;
`ifdef DISPENSE_STATS_EN
            if (coin_total != 8'hFF) coin_total <= coin_total + 8'd1;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        BEG_ON: begin
          if (cnt == PULSE_LAST) begin
            beg_eject <= 1'b0;
            act_beg   <= act_beg - 3'd1;
            state     <= GAP;
            cnt       <= '0;
`ifdef DISPENSE_STATS_EN
            if (coin_total != 8'hFF) coin_total <= coin_total + 8'd1;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ERROR: begin
          if (err_ack) begin
            state    <= IDLE;
            error    <= 1'b0;
            act_beg  <= 3'd0;
            act_obeg <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          candy_sol  <= 1'b0;
          obeg_eject <= 1'b0;
          beg_eject  <= 1'b0;
          error      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer: directed cycle tables of stimulus and
// hand-derived expected outputs {candy_sol, obeg_eject, beg_eject, busy,
// error, overflow}, sampled on the falling clock edge.

module tb_dispense_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       candy;
  logic [2:0] change_beg;
  logic       change_obeg;
  logic       drop_sense;
  logic       err_ack;
  logic       candy_sol;
  logic       obeg_eject;
  logic       beg_eject;
  logic       busy;
  logic       error;
  logic       overflow;
`ifdef DISPENSE_STATS_EN
  logic [7:0] vend_total;
  logic [7:0] coin_total;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       candy;
    logic [2:0] beg;
    logic       obeg;
    logic       drop;
    logic       ack;
  } stim_t;

  stim_t      stim_q[$];
  logic [5:0] exp_q[$];

  dispense_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .candy       (candy),
    .change_beg  (change_beg),
    .change_obeg (change_obeg),
    .drop_sense  (drop_sense),
    .err_ack     (err_ack),
    .candy_sol   (candy_sol),
    .obeg_eject  (obeg_eject),
    .beg_eject   (beg_eject),
    .busy        (busy),
    .error       (error),
    .overflow    (overflow)
`ifdef DISPENSE_STATS_EN
    ,
    .vend_total  (vend_total),
    .coin_total  (coin_total)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] obs();
    return {candy_sol, obeg_eject, beg_eject, busy, error, overflow};
  endfunction

  // Queue one row: expected outputs at this falling edge, then inputs to drive
  task automatic v(input logic c, input logic [2:0] b, input logic o,
                   input logic d, input logic a, input logic [5:0] e);
    stim_t s;
    s.candy = c; s.beg = b; s.obeg = o; s.drop = d; s.ack = a;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic run_vecs(input string name);
    int i;
    stim_t s;
    logic [5:0] e;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      check($sformatf("%s[%0d]", name, i), 16'(obs()), 16'(e));
      candy       = s.candy;
      change_beg  = s.beg;
      change_obeg = s.obeg;
      drop_sense  = s.drop;
      err_ack     = s.ack;
      i++;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, 16'(busy), 16'd0);
  endtask

  initial begin
    reset = 1'b0; candy = 1'b0; change_beg = 3'd0; change_obeg = 1'b0;
    drop_sense = 1'b0; err_ack = 1'b0;
    #1;
    check("reset_outputs", 16'(obs()), 16'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Job beg=3 obeg=1, drop two cycles after the solenoid falls
    v(1,3,1,0,0, 6'b000000);
    v(1,0,0,0,0, 6'b100100);
    v(1,0,0,0,0, 6'b100100);
    v(0,0,0,0,0, 6'b000100);
    v(0,0,0,1,0, 6'b000100);
    v(0,0,0,0,0, 6'b000100);
    v(0,0,0,0,0, 6'b010100);
    v(0,0,0,0,0, 6'b010100);
    v(0,0,0,0,0, 6'b000100);
    v(0,0,0,0,0, 6'b001100);
    v(0,0,0,0,0, 6'b001100);
    v(0,0,0,0,0, 6'b000100);
    v(0,0,0,0,0, 6'b001100);
    v(0,0,0,0,0, 6'b001100);
    v(0,0,0,0,0, 6'b000100);
    v(0,0,0,0,0, 6'b001100);
    v(0,0,0,0,0, 6'b001100);
    v(0,0,0,0,0, 6'b000100);
    v(0,0,0,0,0, 6'b000000);
    run_vecs("full_job");

    // Zero-change job, drop on the first WAIT_DROP cycle
    v(1,0,0,0,0, 6'b000000);
    v(1,0,0,0,0, 6'b100100);
    v(0,0,0,0,0, 6'b100100);
    v(0,0,0,1,0, 6'b000100);
    v(0,0,0,0,0, 6'b000100);
    v(0,0,0,0,0, 6'b000000);
    run_vecs("zero_job");

    // Zero-change job, drop while the solenoid is still on
    v(1,0,0,0,0, 6'b000000);
    v(0,0,0,1,0, 6'b100100);
    v(0,0,0,0,0, 6'b100100);
    v(0,0,0,0,0, 6'b000100);
    v(0,0,0,0,0, 6'b000100);
    v(0,0,0,0,0, 6'b000000);
    run_vecs("early_drop");

    // No drop: error after 8 cycles, request in ERROR overflows, err_ack clears
    v(1,2,1,0,0, 6'b000000);
    v(0,0,0,0,0, 6'b100100);
    v(0,0,0,0,0, 6'b100100);
    for (int k = 0; k < 8; k++) v(0,0,0,0,0, 6'b000100);
    v(1,5,1,0,0, 6'b000110);
    v(1,5,1,0,1, 6'b000111);
    v(0,0,0,0,0, 6'b000000);
    v(0,0,0,0,0, 6'b000000);
    v(0,0,0,0,0, 6'b000000);
    run_vecs("timeout");

    // A(beg=1) active, B(beg=2,obeg=1) queued, C(beg=7,obeg=1) overflows
    v(1,1,0,0,0, 6'b000000);
    v(0,0,0,0,0, 6'b100100);
    v(1,2,1,0,0, 6'b100100);
    v(0,0,0,1,0, 6'b000100);
    v(1,7,1,0,0, 6'b000100);
    v(0,0,0,0,0, 6'b001101);
    v(0,0,0,0,0, 6'b001100);
    v(0,0,0,0,0, 6'b000100);
    v(0,0,0,0,0, 6'b000100);
    v(0,0,0,0,0, 6'b100100);
    v(0,0,0,0,0, 6'b100100);
    v(0,0,0,1,0, 6'b000100);
    v(0,0,0,0,0, 6'b000100);
    v(0,0,0,0,0, 6'b010100);
    v(0,0,0,0,0, 6'b010100);
    v(0,0,0,0,0, 6'b000100);
    v(0,0,0,0,0, 6'b001100);
    v(0,0,0,0,0, 6'b001100);
    v(0,0,0,0,0, 6'b000100);
    v(0,0,0,0,0, 6'b001100);
    v(0,0,0,0,0, 6'b001100);
    v(0,0,0,0,0, 6'b000100);
    for (int k = 0; k < 4; k++) v(0,0,0,0,0, 6'b000000);
    run_vecs("queue");

    // Async reset in the middle of a beg pulse with a job pending
    v(1,1,0,0,0, 6'b000000);
    v(0,0,0,0,0, 6'b100100);
    v(1,2,1,0,0, 6'b100100);
    v(0,0,0,1,0, 6'b000100);
    v(0,0,0,0,0, 6'b000100);
    v(0,0,0,0,0, 6'b001100);
    run_vecs("pre_reset");
    #2 reset = 1'b0;
    #1;
    check("async_reset_drives", 16'(obs()), 16'd0);
`ifdef DISPENSE_STATS_EN
    check("reset_vend_total", 16'(vend_total), 16'd0);
    check("reset_coin_total", 16'(coin_total), 16'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) v(0,0,0,0,0, 6'b000000);
    run_vecs("post_reset");

`ifdef DISPENSE_STATS_EN
    // Max jobs with the drop sensor held high
    drop_sense = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      candy = 1'b1; change_beg = 3'd7; change_obeg = 1'b1;
      @(negedge clk);
      candy = 1'b0;
      wait_idle($sformatf("stats_job_done[%0d]", j), 100);
      if (j == 1) begin
        check("vend_total_2", 16'(vend_total), 16'd2);
        check("coin_total_16", 16'(coin_total), 16'd16);
      end
    end
    check("vend_total_40", 16'(vend_total), 16'd40);
    check("coin_total_sat", 16'(coin_total), 16'd255);
    drop_sense = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dispense_sequencer.md
Name: dispense_sequencer

Overview:
- Downstream stage of the vending controller.
- Consumes the candy strobe and change outputs (change_beg count, change_obeg flag) and sequences the physical actuators:
  - candy solenoid first,
  - then the large-coin (obeg) ejector,
  - then N small-coin (beg) ejector pulses.
- Each actuation is timed, and each candy is confirmed by a drop sensor with a timeout.
- Runs on the same divided clock as the controller, between the controller and the actuator pins.

Parameters:
- PULSE_LEN, 2, actuator on-time in clk cycles (>=1).
- GAP_LEN, 1, mandatory all-off cycles between consecutive actuations (>=1).
- TIMEOUT, 8, cycles allowed for drop_sense after candy pulse ends (>=1).
- CNT_W, 4, width of internal timers (must hold max(PULSE_LEN, GAP_LEN, TIMEOUT)).

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- candy  input  1  vend request level from controller; rising edge = new job
- change_beg  input  3  small-coin count for job, sampled on candy rising edge
- change_obeg  input  1  one large coin for job, sampled on candy rising edge
- drop_sense  input  1  candy drop sensor, synchronous, high for >=1 cycle
- err_ack  input  1  clears error state
- candy_sol  output  1  candy solenoid drive
- obeg_eject  output  1  large-coin ejector drive
- beg_eject  output  1  small-coin ejector drive
- busy  output  1  job in progress or pending
- error  output  1  drop timeout occurred, sticky until err_ack
- overflow  output  1  one-cycle pulse: request dropped

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM=IDLE, pending slot empty, edge register 0.
- Edge detect: candy_q registered. A job is accepted on the cycle where candy=1 and candy_q=0. It latches {change_beg, change_obeg}.
- Job buffer:
  - One active job plus one pending slot.
  - Accept in IDLE: start next cycle.
  - Accept while active and slot empty: store in slot.
  - Accept while slot full, or while in ERROR: discard the job and pulse overflow for 1 cycle.
- FSM states: IDLE, CANDY_ON, WAIT_DROP, GAP, OBEG_ON, BEG_ON, ERROR.
- IDLE:
  - If pending valid, load it into active and go to CANDY_ON.
  - Else, on an edge, load the inputs directly and go to CANDY_ON.
- CANDY_ON: candy_sol=1 for PULSE_LEN cycles, then WAIT_DROP.
- WAIT_DROP:
  - drop_sense=1 → GAP, next target obeg/beg/done.
  - After TIMEOUT cycles without drop → ERROR.
  - drop_sense seen during CANDY_ON also counts; WAIT_DROP then exits on its first cycle.
- GAP:
  - All drives 0 for GAP_LEN cycles.
  - Then OBEG_ON if obeg remaining, else BEG_ON if beg count >0, else job done.
- OBEG_ON: obeg_eject=1 for PULSE_LEN cycles; clear obeg flag; then GAP.
- BEG_ON: beg_eject=1 for PULSE_LEN cycles; decrement count; then GAP.
- Job done: go to IDLE. A pending job therefore starts after exactly GAP_LEN+1 idle cycles from the last pulse end.
- Zero-change job: candy, drop, GAP, done.
- Max job (beg=7, obeg=1): 9 actuations, strictly serial. At most one drive is high in any cycle.
- ERROR:
  - All drives 0, error=1, busy=1.
  - The pending slot is flushed.
  - err_ack=1 → IDLE the next cycle, error=0.
  - The remaining change of the failed job is discarded.
- busy = (state != IDLE) or pending valid.
- Outputs are registered, with no combinational path from inputs.
- Async reset mid-pulse drops all drives immediately.

Optional Feature:
- Macro: DISPENSE_STATS_EN.
- Defined:
  - Adds outputs vend_total [7:0] and coin_total [7:0].
  - vend_total increments on each confirmed drop.
  - coin_total increments at the end of each OBEG_ON/BEG_ON pulse.
  - Both saturate at 255 and clear only on reset.
- Undefined: ports and logic absent; port list as above.

Test Plan:
- Reset then single job (beg=3, obeg=1), drop_sense 2 cycles after candy_sol falls → candy_sol 2 cycles; then obeg_eject ×1 and beg_eject ×3, each 2 cycles with 1-cycle gaps; busy falls after the last gap; error=0.
- Job (beg=0, obeg=0) with drop at the first WAIT_DROP cycle → only candy_sol pulses, busy high 4 cycles total post-accept.
- No drop_sense → error=1 exactly TIMEOUT=8 cycles after candy_sol falls; no coin pulses; err_ack → idle, error=0.
- Three candy rising edges during an active job → second queued and run after the first (GAP_LEN idle between), third gives overflow pulse, and its change is never ejected.
- Async reset asserted during a beg_eject pulse → all drives 0 immediately; after release, busy=0 and pending empty.
- With DISPENSE_STATS_EN, job (beg=7, obeg=1) ×2 → vend_total=2, coin_total=16; 40 such jobs → coin_total saturates at 255.
